// File: rtl/dadda_cpa_pipe.sv
// Final carry-propagate adder for the Dadda tree: two-stage split adder
// with valid/ready on both sides and one register slot per stage.
module dadda_cpa_pipe #(
    parameter int WIDTH = 64,
    parameter int SPLIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_a,
    input  logic [WIDTH-1:0] row_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod,
    output logic             cout
);

    localparam int HW = WIDTH - SPLIT;

    logic             s1_valid;
    logic             s2_valid;
    logic [SPLIT-1:0] lo;
    logic             c1;
    logic [HW-1:0]    ha;
    logic [HW-1:0]    hb;

    logic             s1_adv;
    logic             s2_adv;
    logic             acc;
    logic [SPLIT:0]   lo_sum;
    logic [HW:0]      hi_sum;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign acc      = in_valid && in_ready;

    assign out_valid = s2_valid;

    // One extra bit on each half captures the carry out of that half.
    assign lo_sum = {1'b0, row_a[SPLIT-1:0]} + {1'b0, row_b[SPLIT-1:0]};
    assign hi_sum = {1'b0, ha} + {1'b0, hb} + {{HW{1'b0}}, c1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (acc) begin
            s1_valid <= 1'b1;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (s1_valid && s2_adv) begin
            s2_valid <= 1'b1;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Data flops move only on an advance, so idle X inputs never leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo <= '0;
            c1 <= 1'b0;
            ha <= '0;
            hb <= '0;
        end else if (acc) begin
            lo <= lo_sum[SPLIT-1:0];
            c1 <= lo_sum[SPLIT];
            ha <= row_a[WIDTH-1:SPLIT];
            hb <= row_b[WIDTH-1:SPLIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
            cout <= 1'b0;
        end else if (s1_valid && s2_adv) begin
            prod <= {hi_sum[HW-1:0], lo};
            cout <= hi_sum[HW];
        end
    end

endmodule

// File: tb/tb_dadda_cpa_pipe.sv
// Directed and scoreboarded checks for the two-stage carry-propagate adder.
module tb_dadda_cpa_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] row_a;
    logic [63:0] row_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] prod;
    logic        cout;

    int n_assert;
    int n_fail;
    int n_out;
    int out_mark;
    logic last_acc;
    logic [64:0] exp_q[$];

    dadda_cpa_pipe #(.WIDTH(64), .SPLIT(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .row_a    (row_a),
        .row_b    (row_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .prod     (prod),
        .cout     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs,
                         input logic [64:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: record accepts/drains just before the edge, then
    // advance to 1 time unit past the edge.
    task automatic tick();
        logic        acc;
        logic        drn;
        logic        hold;
        logic [64:0] prev;
        logic [64:0] e;
        #1;
        check("in_ready_model", in_ready,
              !(exp_q.size() >= 2 && !out_ready));
        acc  = in_valid && in_ready;
        drn  = out_valid && out_ready;
        hold = out_valid && !out_ready;
        prev = {cout, prod};
        if (drn) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_output", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", {cout, prod}, e);
                n_out++;
            end
        end
        if (acc) exp_q.push_back({1'b0, row_a} + {1'b0, row_b});
        last_acc = acc;
        @(posedge clk);
        #1;
        if (hold) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", {cout, prod}, prev);
        end
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        n_out     = 0;
        last_acc  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        row_a     = '0;
        row_b     = '0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_prod", prod, 64'h0);
        check("rst_cout", cout, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Carry across the split point
        row_a    = 64'h0000_0000_FFFF_FFFF;
        row_b    = 64'h1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_lat1_valid", out_valid, 1'b0);
        tick();
        check("t1_valid", out_valid, 1'b1);
        check("t1_prod", prod, 64'h0000_0001_0000_0000);
        check("t1_cout", cout, 1'b0);
        tick();
        check("t1_one_cycle", out_valid, 1'b0);

        // Full wrap, then a negative operand
        row_a    = 64'hFFFF_FFFF_FFFF_FFFF;
        row_b    = 64'h1;
        in_valid = 1'b1;
        tick();
        row_a    = 64'hFFFF_FFFF_FFFF_FFFE;
        row_b    = 64'h5;
        tick();
        in_valid = 1'b0;
        check("t2_wrap_prod", prod, 64'h0);
        check("t2_wrap_cout", cout, 1'b1);
        tick();
        check("t2_neg_prod", prod, 64'h3);
        check("t2_neg_cout", cout, 1'b1);
        tick();

        // Back-to-back stream: 100 results in exactly 102 cycles
        out_mark = n_out;
        for (int i = 0; i < 102; i++) begin
            if (i < 100) begin
                in_valid = 1'b1;
                row_a    = {$urandom, $urandom};
                row_b    = {$urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("t3_count", n_out - out_mark, 100);
        check("t3_empty", exp_q.size(), 0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        row_a     = 64'd1;
        row_b     = 64'd2;
        tick();
        row_a = 64'd3;
        row_b = 64'd4;
        tick();
        row_a = 64'd5;
        row_b = 64'd6;
        check("t4_in_ready_low", in_ready, 1'b0);
        check("t4_prod_a", prod, 64'd3);
        tick();
        tick();
        check("t4_still_low", in_ready, 1'b0);
        check("t4_prod_held", prod, 64'd3);
        out_ready = 1'b1;
        #1;
        check("t4_in_ready_up", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t4_prod_b", prod, 64'd7);
        tick();
        check("t4_prod_c", prod, 64'd11);
        check("t4_valid_c", out_valid, 1'b1);
        tick();
        check("t4_drained", out_valid, 1'b0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        row_a     = 64'h1234;
        row_b     = 64'h1111;
        tick();
        tick();
        in_valid = 1'b0;
        check("t5_full_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_valid", out_valid, 1'b0);
        check("t5_async_prod", prod, 64'h0);
        check("t5_async_cout", cout, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t5_no_stale1", out_valid, 1'b0);
        tick();
        check("t5_no_stale2", out_valid, 1'b0);

        // Random valid/ready traffic
        out_mark = n_out;
        last_acc = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = 1'($urandom_range(0, 1));
                row_a    = {$urandom, $urandom};
                row_b    = {$urandom, $urandom};
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t6_drained", exp_q.size(), 0);
        check("t6_some_out", (n_out - out_mark) > 1000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
